// File: rtl/da_lut_prog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | da_lut_prog : runtime-programmable distributed-arithmetic lookup table.    |
// | Coefficients are written, a 2^TAPS entry table is built one entry per      |
// | cycle, then registered lookups are served. Option: DA_LUT_READBACK_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module da_lut_prog #(
  parameter int TAPS   = 8,
  parameter int COEF_W = 32,
  parameter int OUT_W  = 32,
  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int DEPTH = 1 << TAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [IDX_W-1:0]  coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_last,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic [TAPS-1:0]   addr,
  output logic              data_valid,
  output logic [OUT_W-1:0]  data_out,
  output logic              table_valid,
`ifdef DA_LUT_READBACK_EN
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [COEF_W-1:0] rd_coef,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUILD = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COEF_W-1:0]   coef_q [TAPS];
  logic [COEF_W-1:0]   coef_d [TAPS];
  logic [TAPS-1:0]     cnt_q, cnt_d;
  logic                data_valid_q, data_valid_d;
  logic [OUT_W-1:0]    data_out_q, data_out_d;
  logic [OUT_W-1:0]    table_q [DEPTH];

  logic                coef_fire;
  logic                addr_fire;
  logic [TAPS-1:0]     prev_idx;
  logic [IDX_W-1:0]    low_bit;
  logic [OUT_W-1:0]    build_entry;

  assign coef_ready  = (state_q != S_BUILD);
  assign busy        = (state_q == S_BUILD);
  assign table_valid = (state_q == S_READY);
  assign addr_ready  = (state_q == S_READY);
  assign data_valid  = data_valid_q;
  assign data_out    = data_out_q;

  assign coef_fire = coef_valid && coef_ready;
  assign addr_fire = addr_valid && addr_ready;

  // Entry i extends the already-built entry with its lowest set bit cleared.
  assign prev_idx = cnt_q & (cnt_q - 1'b1);

  always_comb begin
    low_bit = '0;
    for (int k = TAPS - 1; k >= 0; k--) begin
      if (cnt_q[k]) low_bit = IDX_W'(k);
    end
  end

  assign build_entry = (cnt_q == '0) ? '0
                     : table_q[prev_idx] + OUT_W'(signed'(coef_q[low_bit]));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    coef_d       = coef_q;
    data_valid_d = addr_fire;
    data_out_d   = addr_fire ? table_q[addr] : data_out_q;

    if (coef_fire && (int'(coef_idx) < TAPS)) begin
      coef_d[coef_idx] = coef_data;
    end

    case (state_q)
      S_IDLE, S_READY: begin
        if (coef_fire && coef_last) begin
          state_d = S_BUILD;
          cnt_d   = '0;
        end
      end
      S_BUILD: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      coef_q       <= coef_d;
    end
  end

  // Table storage is deliberately left unreset; table_valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == S_BUILD)) begin
      table_q[cnt_q] <= build_entry;
    end
  end

`ifdef DA_LUT_READBACK_EN
  logic [COEF_W-1:0] rd_coef_q, rd_coef_d;

  assign rd_coef_d = (int'(rd_idx) < TAPS) ? coef_q[rd_idx] : '0;
  assign rd_coef   = rd_coef_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_coef_q <= '0;
    else        rd_coef_q <= rd_coef_d;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_da_lut_prog.sv
`default_nettype none
// Testbench for da_lut_prog (TAPS=8, COEF_W=OUT_W=32) with a sum-of-set-bits
// reference model; exercises DA_LUT_READBACK_EN ports when that macro is set.
module tb_da_lut_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_valid, coef_ready, coef_last;
  logic [2:0]  coef_idx;
  logic [31:0] coef_data;
  logic        addr_valid, addr_ready;
  logic [7:0]  addr;
  logic        data_valid;
  logic [31:0] data_out;
  logic        table_valid, busy;
`ifdef DA_LUT_READBACK_EN
  logic [2:0]  rd_idx;
  logic [31:0] rd_coef;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mcoef [8];
  logic [31:0] held;

  always #5 clk = ~clk;

  da_lut_prog #(.TAPS(8), .COEF_W(32), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_idx(coef_idx),
    .coef_data(coef_data), .coef_last(coef_last),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .data_valid(data_valid), .data_out(data_out), .table_valid(table_valid),
`ifdef DA_LUT_READBACK_EN
    .rd_idx(rd_idx), .rd_coef(rd_coef),
`endif
    .busy(busy)
  );

  function automatic logic [31:0] ref_entry(input int a);
    logic [31:0] s = 32'd0;
    for (int k = 0; k < 8; k++) if (((a >> k) & 1) == 1) s = s + mcoef[k];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic write_coef(input int idx, input logic [31:0] d, input logic last);
    coef_valid = 1'b1;
    coef_idx   = 3'(idx);
    coef_data  = d;
    coef_last  = last;
    mcoef[idx] = d;
    @(negedge clk);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  // Entered on the first cycle after coef_last was accepted.
  task automatic wait_build();
    int nb = 0;
    chk("tv_in_build", {31'd0, table_valid}, 32'd0);
    chk("coef_ready_in_build", {31'd0, coef_ready}, 32'd0);
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      nb++;
      @(negedge clk);
    end
    chk("build_cycles", nb, 32'd256);
    chk("tv_after_build", {31'd0, table_valid}, 32'd1);
    chk("busy_after_build", {31'd0, busy}, 32'd0);
  endtask

  task automatic lookup(input int a, input logic [31:0] exp);
    addr_valid = 1'b1;
    addr       = 8'(a);
    @(negedge clk);
    addr_valid = 1'b0;
    chk("lookup_valid", {31'd0, data_valid}, 32'd1);
    chk("lookup_data", data_out, exp);
    held = exp;
  endtask

  initial begin
    rst_n = 1'b0; coef_valid = 1'b0; coef_last = 1'b0; coef_idx = '0;
    coef_data = '0; addr_valid = 1'b0; addr = '0; held = '0;
    for (int k = 0; k < 8; k++) mcoef[k] = '0;
`ifdef DA_LUT_READBACK_EN
    rd_idx = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_table_valid", {31'd0, table_valid}, 32'd0);
    chk("rst_addr_ready", {31'd0, addr_ready}, 32'd0);
    chk("rst_coef_ready", {31'd0, coef_ready}, 32'd1);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef DA_LUT_READBACK_EN
    chk("rst_rd_coef", rd_coef, 32'd0);
`endif

    // Directed coefficient set
    write_coef(0, 32'd1, 1'b0);
    write_coef(1, 32'd1, 1'b0);
    write_coef(2, -32'sd5, 1'b0);
    write_coef(3, -32'sd12, 1'b0);
    write_coef(4, 32'd22, 1'b0);
    write_coef(5, 32'd39, 1'b0);
    write_coef(6, -32'sd62, 1'b0);
    chk("idle_tv_before_last", {31'd0, table_valid}, 32'd0);
    write_coef(7, -32'sd94, 1'b1);
    wait_build();

    lookup(8'h00, 32'h0000_0000);
    lookup(8'h03, 32'h0000_0002);
    lookup(8'h80, 32'hFFFF_FFA2);
    lookup(8'hFF, 32'hFFFF_FF92);
    @(negedge clk);
    chk("idle_data_valid", {31'd0, data_valid}, 32'd0);
    chk("idle_data_hold", data_out, held);

`ifdef DA_LUT_READBACK_EN
    rd_idx = 3'd7;
    @(negedge clk);
    chk("readback_7", rd_coef, 32'hFFFF_FFA2);
`endif

    // Back-to-back lookups over the whole table
    addr_valid = 1'b1;
    addr       = 8'h00;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, data_valid}, 32'd1);
      chk("b2b_data", data_out, ref_entry(i - 1));
      if (i < 256) addr = 8'(i);
      else         addr_valid = 1'b0;
    end
    held = ref_entry(255);

    // Non-final write keeps the old table valid
    write_coef(0, 32'd100, 1'b0);
    chk("tv_after_plain_write", {31'd0, table_valid}, 32'd1);
    lookup(8'h01, 32'd1);

    // coef_last together with a lookup: old table serves it, then rebuild
    coef_valid = 1'b1; coef_idx = 3'd7; coef_data = -32'sd94; coef_last = 1'b1;
    addr_valid = 1'b1; addr = 8'h01;
    @(negedge clk);
    coef_valid = 1'b0; coef_last = 1'b0; addr_valid = 1'b0;
    chk("concurrent_valid", {31'd0, data_valid}, 32'd1);
    chk("concurrent_old_data", data_out, 32'd1);
    chk("concurrent_addr_ready", {31'd0, addr_ready}, 32'd0);
    wait_build();
    lookup(8'h01, 32'd100);
    lookup(8'hFF, ref_entry(255));

    // Random coefficients and random lookup traffic
    for (int k = 0; k < 8; k++) write_coef(k, $urandom, (k == 7) ? 1'b1 : 1'b0);
    wait_build();
    for (int c = 0; c < 200; c++) begin
      logic v;
      int   a;
      v = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255);
      addr_valid = v;
      addr       = 8'(a);
      @(negedge clk);
      chk("rnd_valid", {31'd0, data_valid}, {31'd0, v});
      if (v) held = ref_entry(a);
      chk("rnd_data", data_out, held);
    end
    addr_valid = 1'b0;

    // Reset at build cycle 40 aborts the build and clears coefficients
    write_coef(3, 32'h1234_5678, 1'b1);
    repeat (39) @(negedge clk);
    chk("busy_at_40", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_table_valid", {31'd0, table_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_coef_ready", {31'd0, coef_ready}, 32'd1);
    chk("abort_addr_ready", {31'd0, addr_ready}, 32'd0);
    chk("abort_data_out", data_out, 32'd0);
    for (int k = 0; k < 8; k++) mcoef[k] = '0;
`ifdef DA_LUT_READBACK_EN
    rd_idx = 3'd3;
    @(negedge clk);
    chk("abort_rd_coef", rd_coef, 32'd0);
`endif
    // Only tap 0 is rewritten, so a zero result proves the others were cleared
    write_coef(0, 32'd0, 1'b1);
    wait_build();
    lookup(8'hFF, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
